mdr_ctrl: RTL

MDR_CTRL -- requirements
Module: mdr_ctrl

---
 rtl/mdr_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mdr_ctrl.sv
// Sequences mul/div/sqrt operands from a switch register and collects unit results; start 1 cycle after final load.
// Result/valid 1 cycle after matching done; no backpressure, loads are ignored while an operation is in flight.
module mdr_ctrl #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [DW-1:0]   i_data,
  input  logic [1:0]      i_op,
  output logic [2:0]      o_start,
  input  logic [2:0]      i_done,
  input  logic [2*DW-1:0] i_res,
  output logic [DW-1:0]   o_opa,
  output logic [DW-1:0]   o_opb,
  output logic [1:0]      o_sel,
  output logic [2*DW-1:0] o_result,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_err,
  output logic [1:0]      o_err_code
);

  typedef enum logic [2:0] {IDLE, WAIT_B, START, BUSY, ERROR} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    sel_onehot;
  logic          done_hit, timeout;
  logic          cap_a, cap_sqrt, cap_b, do_done, set_dz, set_to, clr_err;

  always_comb begin
    sel_onehot = 3'b000;
    case (o_sel)
      2'b01:   sel_onehot = 3'b001;
      2'b10:   sel_onehot = 3'b010;
      2'b11:   sel_onehot = 3'b100;
      default: sel_onehot = 3'b000;
    endcase
  end

  assign done_hit = |(i_done & sel_onehot);
  // cnt is 0 during START and counts every cycle after, so it equals cycles since start
  assign timeout  = (cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_sqrt  = 1'b0;
    cap_b     = 1'b0;
    do_done   = 1'b0;
    set_dz    = 1'b0;
    set_to    = 1'b0;
    clr_err   = 1'b0;
    case (state)
      IDLE: begin
        if (i_load && i_op == 2'b11) begin
          cap_sqrt  = 1'b1;
          state_nxt = START;
        end else if (i_load && i_op != 2'b00) begin
          cap_a     = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_load) begin
          if (o_sel == 2'b10 && i_data == '0) begin
            set_dz    = 1'b1;
            state_nxt = ERROR;
          end else begin
            cap_b     = 1'b1;
            state_nxt = START;
          end
        end
      end
      START: state_nxt = BUSY;
      BUSY: begin
        // a matching done wins over a timeout landing in the same cycle
        if (done_hit) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          set_to    = 1'b1;
          state_nxt = ERROR;
        end
      end
      ERROR: begin
        if (i_load) begin
          clr_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_opa      <= '0;
      o_opb      <= '0;
      o_sel      <= '0;
      o_result   <= '0;
      o_valid    <= 1'b0;
      o_err_code <= '0;
      cnt        <= '0;
    end else begin
      o_valid <= do_done;
      if (cap_a) begin
        o_opa <= i_data;
        o_sel <= i_op;
      end
      if (cap_sqrt) begin
        o_opa <= i_data;
        o_opb <= '0;
        o_sel <= 2'b11;
      end
      if (cap_b)   o_opb      <= i_data;
      if (do_done) o_result   <= i_res;
      if (set_dz)  o_err_code <= 2'b01;
      if (set_to)  o_err_code <= 2'b10;
      if (clr_err) o_err_code <= 2'b00;
      if (state_nxt == START)                 cnt <= '0;
      else if (state == START || state == BUSY) cnt <= cnt + CW'(1);
    end
  end

  assign o_start = (state == START) ? sel_onehot : 3'b000;
  assign o_busy  = (state == WAIT_B) || (state == START) || (state == BUSY);
  assign o_err   = (state == ERROR);

endmodule
